// File: rtl/mem_pkg.sv
// Shared types and constants for the behavioural dual-port memory model.
// Holds the per-port FSM state encoding and the latency/byte counter width.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ_BUSY,
        READ_DONE,
        WRITE_BUSY,
        WRITE_DONE
    } mem_state_e;

    // Wide enough for a 16-cycle read wait and a 32-byte access.
    localparam int unsigned LAT_CNT_W = 5;

    function automatic int unsigned size_bits(input int unsigned fetch_width);
        return (fetch_width > 8) ? $clog2(fetch_width / 8) : 1;
    endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// One memory port sequencer: counts read wait cycles down, or write bytes up,
// then holds DONE for one cycle. Requests are only taken in IDLE.
module mem_port_fsm
    import mem_pkg::*;
#(
    parameter int unsigned RD_BUSY_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_req,
    input  logic                 wr_req,
    input  logic [LAT_CNT_W-1:0] wr_last,
    output mem_state_e           state,
    output logic [LAT_CNT_W-1:0] cnt,
    output logic                 busy,
    output logic                 rdy
);

    localparam int unsigned RD_LOAD_INT = (RD_BUSY_CYCLES == 0) ? 0 : RD_BUSY_CYCLES - 1;
    localparam logic [LAT_CNT_W-1:0] RD_LOAD = LAT_CNT_W'(RD_LOAD_INT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            rdy   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rd_req) begin
                        busy <= 1'b1;
                        if (RD_BUSY_CYCLES == 0) begin
                            state <= READ_DONE;
                            rdy   <= 1'b1;
                        end else begin
                            state <= READ_BUSY;
                            cnt   <= RD_LOAD;
                        end
                    end else if (wr_req) begin
                        state <= WRITE_BUSY;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                READ_BUSY: begin
                    if (cnt == '0) begin
                        state <= READ_DONE;
                        rdy   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                // cnt doubles as the byte index being written this cycle
                WRITE_BUSY: begin
                    if (cnt == wr_last) begin
                        state <= WRITE_DONE;
                        rdy   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READ_DONE, WRITE_DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    rdy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    rdy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_behavioural_mp.sv
// Behavioural byte-addressed memory with an independent data port (read/write)
// and instruction port (32-bit read). Define MEM_BOUNDS_CHECK_EN to fault
// out-of-range dmem accesses instead of wrapping them.
module mem_behavioural_mp
    import mem_pkg::*;
#(
    parameter int unsigned     DATA_WIDTH      = 64,
    parameter int unsigned     FETCH_WIDTH     = 64,
    parameter longint unsigned DMEM_SIZE_BYTES = 64'h10000,
    parameter longint unsigned IMEM_SIZE_BYTES = 64'h10000,
    parameter int unsigned     DMEM_RD_LATENCY = 1,
    parameter int unsigned     IMEM_RD_LATENCY = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              dmem_rd_en_i,
    input  logic                              dmem_wr_en_i,
    input  logic                              imem_rd_en_i,
    input  logic [DATA_WIDTH-1:0]             dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]             imem_addr_i,
    input  logic [size_bits(FETCH_WIDTH)-1:0] dmem_size_i,
    input  logic [FETCH_WIDTH-1:0]            dmem_wr_data_i,
    output logic                              dmem_busy_o,
    output logic                              imem_busy_o,
    output logic                              dmem_rdy_o,
    output logic                              imem_rdy_o,
    output logic [FETCH_WIDTH-1:0]            dmem_rd_data_o,
    output logic [31:0]                       imem_rd_data_o,
    output logic                              dmem_fault_o
);

    localparam int unsigned NBYTES = FETCH_WIDTH / 8;
    localparam int unsigned SW     = size_bits(FETCH_WIDTH);
    localparam int unsigned DAW    = $clog2(DMEM_SIZE_BYTES);
    localparam int unsigned AW1    = DATA_WIDTH + 1;

    // Single backing array; the imem port sees its own window at the bottom of it.
    logic [7:0] mem [0:DMEM_SIZE_BYTES-1];

    logic [DATA_WIDTH-1:0]  d_addr_q;
    logic [SW-1:0]          d_size_q;
    logic [FETCH_WIDTH-1:0] d_wdata_q;
    logic [DATA_WIDTH-1:0]  i_addr_q;
    logic                   d_blocked;

    mem_state_e             dmem_state;
    logic [LAT_CNT_W-1:0]   d_cnt;
    mem_state_e             imem_state_unused;
    logic [LAT_CNT_W-1:0]   imem_cnt_unused;

    function automatic logic [DAW-1:0] dmem_index(input logic [DATA_WIDTH-1:0] base,
                                                  input int unsigned offset);
        logic [DATA_WIDTH-1:0] a;
        a = base + DATA_WIDTH'(offset);
        return DAW'(a % DATA_WIDTH'(DMEM_SIZE_BYTES));
    endfunction

    function automatic logic [DAW-1:0] imem_index(input logic [DATA_WIDTH-1:0] base,
                                                  input int unsigned offset);
        logic [DATA_WIDTH-1:0] a;
        a = (base + DATA_WIDTH'(offset)) % DATA_WIDTH'(IMEM_SIZE_BYTES);
        return DAW'(a % DATA_WIDTH'(DMEM_SIZE_BYTES));
    endfunction

    mem_port_fsm #(
        .RD_BUSY_CYCLES (DMEM_RD_LATENCY + 1)
    ) u_dmem_fsm (
        .clk     (clk),
        .rst     (rst),
        .rd_req  (dmem_rd_en_i),
        .wr_req  (dmem_wr_en_i),
        .wr_last (LAT_CNT_W'(d_size_q)),
        .state   (dmem_state),
        .cnt     (d_cnt),
        .busy    (dmem_busy_o),
        .rdy     (dmem_rdy_o)
    );

    mem_port_fsm #(
        .RD_BUSY_CYCLES (IMEM_RD_LATENCY)
    ) u_imem_fsm (
        .clk     (clk),
        .rst     (rst),
        .rd_req  (imem_rd_en_i),
        .wr_req  (1'b0),
        .wr_last ('0),
        .state   (imem_state_unused),
        .cnt     (imem_cnt_unused),
        .busy    (imem_busy_o),
        .rdy     (imem_rdy_o)
    );

    // Request fields are captured on every IDLE cycle, so they are frozen once busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_addr_q  <= '0;
            d_size_q  <= '0;
            d_wdata_q <= '0;
            i_addr_q  <= '0;
        end else begin
            if (dmem_state == IDLE) begin
                d_addr_q  <= dmem_addr_i;
                d_size_q  <= dmem_size_i;
                d_wdata_q <= dmem_wr_data_i;
            end
            if (!imem_busy_o) begin
                i_addr_q <= imem_addr_i;
            end
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    logic           d_fault_q;
    logic [AW1-1:0] d_last_byte;

    assign d_last_byte = {1'b0, dmem_addr_i} + AW1'(dmem_size_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            d_fault_q <= 1'b0;
        end else if (dmem_state == IDLE) begin
            d_fault_q <= d_last_byte > AW1'(DMEM_SIZE_BYTES - 1);
        end
    end

    assign d_blocked    = d_fault_q;
    assign dmem_fault_o = d_fault_q & dmem_rdy_o;
`else
    assign d_blocked    = 1'b0;
    assign dmem_fault_o = 1'b0;
`endif

    // Gating on rst lets a reset mid-write stop before the current byte lands.
    always_ff @(posedge clk) begin
        if (!rst && dmem_state == WRITE_BUSY && !d_blocked) begin
            mem[dmem_index(d_addr_q, 32'(d_cnt))] <= 8'(d_wdata_q >> {d_cnt, 3'b000});
        end
    end

    always_comb begin
        dmem_rd_data_o = '0;
        if (dmem_state == READ_DONE && !d_blocked) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (i <= 32'(d_size_q)) begin
                    dmem_rd_data_o[8*i +: 8] = mem[dmem_index(d_addr_q, i)];
                end
            end
        end
    end

    always_comb begin
        imem_rd_data_o = '0;
        if (imem_rdy_o) begin
            for (int unsigned i = 0; i < 4; i++) begin
                imem_rd_data_o[8*i +: 8] = mem[imem_index(i_addr_q, i)];
            end
        end
    end

endmodule

// File: tb/tb_mem_behavioural_mp.sv
// Directed bench for mem_behavioural_mp (default latencies: dmem 1, imem 0).
// Expectations for the wrapping write switch on MEM_BOUNDS_CHECK_EN.
module tb_mem_behavioural_mp;

    logic        clk;
    logic        rst;
    logic        dmem_rd_en_i, dmem_wr_en_i, imem_rd_en_i;
    logic [63:0] dmem_addr_i, imem_addr_i;
    logic [2:0]  dmem_size_i;
    logic [63:0] dmem_wr_data_i;
    logic        dmem_busy_o, imem_busy_o, dmem_rdy_o, imem_rdy_o;
    logic [63:0] dmem_rd_data_o;
    logic [31:0] imem_rd_data_o;
    logic        dmem_fault_o;

    int checks;
    int failures;

    mem_behavioural_mp #(
        .DATA_WIDTH      (64),
        .FETCH_WIDTH     (64),
        .DMEM_SIZE_BYTES (64'h10000),
        .IMEM_SIZE_BYTES (64'h10000),
        .DMEM_RD_LATENCY (1),
        .IMEM_RD_LATENCY (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dmem_rd_en_i   (dmem_rd_en_i),
        .dmem_wr_en_i   (dmem_wr_en_i),
        .imem_rd_en_i   (imem_rd_en_i),
        .dmem_addr_i    (dmem_addr_i),
        .imem_addr_i    (imem_addr_i),
        .dmem_size_i    (dmem_size_i),
        .dmem_wr_data_i (dmem_wr_data_i),
        .dmem_busy_o    (dmem_busy_o),
        .imem_busy_o    (imem_busy_o),
        .dmem_rdy_o     (dmem_rdy_o),
        .imem_rdy_o     (imem_rdy_o),
        .dmem_rd_data_o (dmem_rd_data_o),
        .imem_rd_data_o (imem_rd_data_o),
        .dmem_fault_o   (dmem_fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one dmem request from IDLE and waits (bounded) for the DONE cycle.
    // n = cycles observed busy before rdy; returns data/fault seen in the DONE cycle.
    task automatic dmem_op(input logic rd, input logic wr, input logic [63:0] addr,
                           input logic [2:0] size, input logic [63:0] wdata,
                           output int n, output logic [63:0] rdata, output logic flt);
        dmem_rd_en_i   = rd;
        dmem_wr_en_i   = wr;
        dmem_addr_i    = addr;
        dmem_size_i    = size;
        dmem_wr_data_i = wdata;
        step();
        dmem_rd_en_i = 1'b0;
        dmem_wr_en_i = 1'b0;
        n = 0;
        while (dmem_rdy_o !== 1'b1 && n < 40) begin
            n++;
            step();
        end
        rdata = dmem_rd_data_o;
        flt   = dmem_fault_o;
        step();
    endtask

    int          n;
    logic [63:0] rd;
    logic        f;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        dmem_rd_en_i = 1'b0; dmem_wr_en_i = 1'b0; imem_rd_en_i = 1'b0;
        dmem_addr_i = '0; imem_addr_i = '0; dmem_size_i = '0; dmem_wr_data_i = '0;
        step(); step(); step();
        chk("rst_dmem_busy", 64'(dmem_busy_o), 64'h0);
        chk("rst_imem_busy", 64'(imem_busy_o), 64'h0);
        chk("rst_dmem_rdy",  64'(dmem_rdy_o),  64'h0);
        chk("rst_imem_rdy",  64'(imem_rdy_o),  64'h0);
        chk("rst_dmem_data", dmem_rd_data_o,   64'h0);
        chk("rst_imem_data", 64'(imem_rd_data_o), 64'h0);
        chk("rst_fault",     64'(dmem_fault_o), 64'h0);
        rst = 1'b0;
        step();

        // 8-byte write then read back
        dmem_op(1'b0, 1'b1, 64'h10, 3'd7, 64'h1122334455667788, n, rd, f);
        chk("wr8_busy_cycles", 64'(n), 64'd8);
        chk("wr8_done_data",   rd,     64'h0);
        chk("wr8_fault",       64'(f), 64'h0);
        chk("wr8_idle_after",  64'(dmem_busy_o), 64'h0);
        dmem_op(1'b1, 1'b0, 64'h10, 3'd7, 64'h0, n, rd, f);
        chk("rd8_busy_cycles", 64'(n), 64'd2);
        chk("rd8_data",        rd,     64'h1122334455667788);
        dmem_op(1'b1, 1'b0, 64'h12, 3'd1, 64'h0, n, rd, f);
        chk("rd2_data",        rd,     64'h0000000000005566);
        dmem_op(1'b1, 1'b0, 64'h17, 3'd0, 64'h0, n, rd, f);
        chk("rd1_top_byte",    rd,     64'h11);

        // request while busy is ignored, including its address
        dmem_rd_en_i = 1'b1; dmem_addr_i = 64'h10; dmem_size_i = 3'd0;
        step();
        dmem_rd_en_i = 1'b0;
        chk("busy_data_zero", dmem_rd_data_o, 64'h0);
        chk("busy_rdy_low",   64'(dmem_rdy_o), 64'h0);
        dmem_wr_en_i = 1'b1; dmem_addr_i = 64'h17; dmem_size_i = 3'd0; dmem_wr_data_i = 64'h55;
        step();
        dmem_wr_en_i = 1'b0;
        step();
        chk("ignored_rdy",    64'(dmem_rdy_o), 64'h1);
        chk("ignored_data",   dmem_rd_data_o, 64'h88);
        step();
        dmem_op(1'b1, 1'b0, 64'h17, 3'd0, 64'h0, n, rd, f);
        chk("ignored_no_write", rd, 64'h11);

        // write crossing the top of the array
        dmem_op(1'b0, 1'b1, 64'h0, 3'd1, 64'h9999, n, rd, f);
        dmem_op(1'b0, 1'b1, 64'hFFFE, 3'd1, 64'h8877, n, rd, f);
        chk("pre_wrap_fault", 64'(f), 64'h0);
        dmem_op(1'b0, 1'b1, 64'hFFFE, 3'd3, 64'hAABBCCDD, n, rd, f);
        chk("wrap_busy_cycles", 64'(n), 64'd4);
`ifdef MEM_BOUNDS_CHECK_EN
        chk("wrap_fault", 64'(f), 64'h1);
        chk("wrap_fault_clears", 64'(dmem_fault_o), 64'h0);
        dmem_op(1'b1, 1'b0, 64'hFFFE, 3'd1, 64'h0, n, rd, f);
        chk("wrap_top_unchanged", rd, 64'h8877);
        dmem_op(1'b1, 1'b0, 64'h0, 3'd1, 64'h0, n, rd, f);
        chk("wrap_low_unchanged", rd, 64'h9999);
        dmem_op(1'b1, 1'b0, 64'hFFFD, 3'd3, 64'h0, n, rd, f);
        chk("oob_read_fault", 64'(f), 64'h1);
        chk("oob_read_zero",  rd,     64'h0);
`else
        chk("wrap_fault", 64'(f), 64'h0);
        dmem_op(1'b1, 1'b0, 64'hFFFE, 3'd1, 64'h0, n, rd, f);
        chk("wrap_top_bytes", rd, 64'hCCDD);
        dmem_op(1'b1, 1'b0, 64'h0, 3'd1, 64'h0, n, rd, f);
        chk("wrap_low_bytes", rd, 64'hAABB);
        dmem_op(1'b1, 1'b0, 64'hFFFE, 3'd3, 64'h0, n, rd, f);
        chk("wrap_read4", rd, 64'hAABBCCDD);
`endif

        // reset on the 3rd WRITE_BUSY cycle aborts after two bytes
        dmem_op(1'b0, 1'b1, 64'h40, 3'd7, 64'h0807060504030201, n, rd, f);
        dmem_wr_en_i = 1'b1; dmem_addr_i = 64'h40; dmem_size_i = 3'd7;
        dmem_wr_data_i = 64'hF8F7F6F5F4F3F2F1;
        step();
        dmem_wr_en_i = 1'b0;
        step();
        step();
        chk("abort_busy_before", 64'(dmem_busy_o), 64'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy_after", 64'(dmem_busy_o), 64'h0);
        chk("abort_rdy_after",  64'(dmem_rdy_o),  64'h0);
        dmem_op(1'b1, 1'b0, 64'h40, 3'd7, 64'h0, n, rd, f);
        chk("abort_partial", rd, 64'h080706050403F2F1);

        // simultaneous rd+wr on dmem with a concurrent imem fetch
        dmem_op(1'b0, 1'b1, 64'h20, 3'd3, 64'hDEADBEEF, n, rd, f);
        dmem_rd_en_i = 1'b1; dmem_wr_en_i = 1'b1; dmem_addr_i = 64'h10; dmem_size_i = 3'd7;
        dmem_wr_data_i = 64'hFFFFFFFFFFFFFFFF;
        imem_rd_en_i = 1'b1; imem_addr_i = 64'h20;
        step();
        dmem_rd_en_i = 1'b0; dmem_wr_en_i = 1'b0; imem_rd_en_i = 1'b0;
        chk("conc_imem_rdy",  64'(imem_rdy_o), 64'h1);
        chk("conc_imem_busy", 64'(imem_busy_o), 64'h1);
        chk("conc_imem_data", 64'(imem_rd_data_o), 64'hDEADBEEF);
        chk("conc_dmem_busy", 64'(dmem_busy_o), 64'h1);
        chk("conc_dmem_rdy0", 64'(dmem_rdy_o), 64'h0);
        step();
        chk("conc_imem_idle", 64'(imem_busy_o), 64'h0);
        chk("conc_imem_zero", 64'(imem_rd_data_o), 64'h0);
        chk("conc_dmem_rdy1", 64'(dmem_rdy_o), 64'h0);
        step();
        chk("conc_dmem_rdy2", 64'(dmem_rdy_o), 64'h1);
        chk("conc_dmem_read", dmem_rd_data_o, 64'h1122334455667788);
        step();
        chk("conc_dmem_idle", 64'(dmem_busy_o), 64'h0);

        // imem word fetch at another address
        imem_rd_en_i = 1'b1; imem_addr_i = 64'h12;
        step();
        imem_rd_en_i = 1'b0;
        chk("imem_word_12", 64'(imem_rd_data_o), 64'h33445566);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
